// File: rtl/i2c_bit_ctrl.sv
// i2c_bit_ctrl -- bit-level I2C engine.
//
// Executes one bus primitive (START, STOP, WRITE bit, READ bit) per accepted
// command. Each primitive takes four phases (P0..P3). Phases advance on the
// quarter-SCL-period strobe from the clock divider.
//
// Ports:
//   clk_i, arstn_i         system clock; asynchronous active-low reset
//   tick_i                 quarter-period strobe; phases advance only when tick_i=1
//   cmd_valid_i/cmd_ready_o command handshake; cmd_i/din_i are captured at accept
//   cmd_i                  00 START, 01 STOP, 10 WRITE, 11 READ
//   din_i                  bit to send for WRITE
//   done_o                 one-cycle pulse when a command finishes
//   dout_o                 bit sampled by the last READ
//   arb_lost_o             qualifies done_o: WRITE lost arbitration
//   bus_busy_o             a START was seen on the bus and no STOP yet (any master)
//   scl_i, sda_i           pad levels
//   scl_oe_o, sda_oe_o     open-drain enables (1 = pull low)
module i2c_bit_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       arstn_i,
  input  logic       tick_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_i,
  input  logic       din_i,
  output logic       done_o,
  output logic       dout_o,
  output logic       arb_lost_o,
  output logic       bus_busy_o,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe_o,
  output logic       sda_oe_o
);

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;

  typedef enum logic [2:0] {IDLE, P0, P1, P2, P3} state_t;

  state_t state_reg, state_next;
  logic [1:0] cmd_reg, cmd_next;
  logic       din_reg, din_next;
  logic       scl_oe_reg, scl_oe_next;
  logic       sda_oe_reg, sda_oe_next;
  logic       done_reg, done_next;
  logic       arb_reg, arb_next;
  logic       dout_reg, dout_next;
  logic       busy_reg, busy_next;
  logic       sda_prev_reg;

  // Pad synchronisers, preset high to match an idle (pulled-up) bus.
  logic [SYNC_STAGES-1:0] scl_sync_reg, sda_sync_reg;
  logic scl_s, sda_s;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      scl_sync_reg <= '1;
      sda_sync_reg <= '1;
    end else begin
      scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl_i};
      sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda_i};
    end
  end

  assign scl_s = scl_sync_reg[SYNC_STAGES-1];
  assign sda_s = sda_sync_reg[SYNC_STAGES-1];

  // Bus-level START/STOP detection, watching every master on the bus.
  always_comb begin
    busy_next = busy_reg;
    if (!sda_prev_reg && sda_s && scl_s) begin
      busy_next = 1'b0;
    end else if (sda_prev_reg && !sda_s && scl_s) begin
      busy_next = 1'b1;
    end
  end

  // Phase sequencing plus registered line enables. The enables are computed
  // for the phase being entered so the pads change on the same edge as the
  // state register and never glitch through decode logic.
  always_comb begin
    state_next  = state_reg;
    cmd_next    = cmd_reg;
    din_next    = din_reg;
    scl_oe_next = scl_oe_reg;
    sda_oe_next = sda_oe_reg;
    done_next   = 1'b0;
    arb_next    = 1'b0;
    dout_next   = dout_reg;

    case (state_reg)
      IDLE: begin
        if (cmd_valid_i) begin
          state_next = P0;
          cmd_next   = cmd_i;
          din_next   = din_i;
        end
      end
      P0: if (tick_i) state_next = P1;
      // Clock stretching: a slave holding SCL low keeps us here.
      P1: if (tick_i && scl_s) state_next = P2;
      P2: begin
        if (tick_i) begin
          if (cmd_reg == CMD_READ) dout_next = sda_s;
          // We released SDA to send a 1 but someone else drives 0.
          if (cmd_reg == CMD_WRITE && din_reg && !sda_s) begin
            state_next = IDLE;
            done_next  = 1'b1;
            arb_next   = 1'b1;
          end else begin
            state_next = P3;
          end
        end
      end
      P3: begin
        if (tick_i) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (arb_next) begin
      scl_oe_next = 1'b0;
      sda_oe_next = 1'b0;
    end else begin
      case (state_next)
        P0: begin
          case (cmd_next)
            // SCL keeps its previous level so a repeated START works.
            CMD_START: sda_oe_next = 1'b0;
            CMD_STOP:  begin scl_oe_next = 1'b1; sda_oe_next = 1'b1;      end
            CMD_WRITE: begin scl_oe_next = 1'b1; sda_oe_next = ~din_next; end
            default:   begin scl_oe_next = 1'b1; sda_oe_next = 1'b0;      end
          endcase
        end
        P1: begin
          scl_oe_next = 1'b0;
          case (cmd_next)
            CMD_STOP:  sda_oe_next = 1'b1;
            CMD_WRITE: sda_oe_next = ~din_next;
            default:   sda_oe_next = 1'b0;
          endcase
        end
        P2: begin
          scl_oe_next = 1'b0;
          case (cmd_next)
            CMD_START: sda_oe_next = 1'b1;
            CMD_WRITE: sda_oe_next = ~din_next;
            default:   sda_oe_next = 1'b0;
          endcase
        end
        P3: begin
          case (cmd_next)
            CMD_START: begin scl_oe_next = 1'b1; sda_oe_next = 1'b1;      end
            CMD_STOP:  begin scl_oe_next = 1'b0; sda_oe_next = 1'b0;      end
            CMD_WRITE: begin scl_oe_next = 1'b1; sda_oe_next = ~din_next; end
            default:   begin scl_oe_next = 1'b1; sda_oe_next = 1'b0;      end
          endcase
        end
        default: ; // IDLE holds the lines where the last command left them
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_reg    <= IDLE;
      cmd_reg      <= CMD_START;
      din_reg      <= 1'b0;
      scl_oe_reg   <= 1'b0;
      sda_oe_reg   <= 1'b0;
      done_reg     <= 1'b0;
      arb_reg      <= 1'b0;
      dout_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      sda_prev_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      cmd_reg      <= cmd_next;
      din_reg      <= din_next;
      scl_oe_reg   <= scl_oe_next;
      sda_oe_reg   <= sda_oe_next;
      done_reg     <= done_next;
      arb_reg      <= arb_next;
      dout_reg     <= dout_next;
      busy_reg     <= busy_next;
      sda_prev_reg <= sda_s;
    end
  end

  assign cmd_ready_o = (state_reg == IDLE);
  assign done_o      = done_reg;
  assign arb_lost_o  = arb_reg;
  assign dout_o      = dout_reg;
  assign bus_busy_o  = busy_reg;
  assign scl_oe_o    = scl_oe_reg;
  assign sda_oe_o    = sda_oe_reg;

endmodule
